mem_arbiter: RTL and testbench

//   Shares the single-port 32x32 word Memory between instruction fetch (IF, read-only) and load/store (D).

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arb_select.sv | 46 ++++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the IF/D memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_D  = 1'b1;

   localparam int DEF_AW = 5;
   localparam int DEF_DW = 32;

endpackage

// File: rtl/mem_arb_select.sv
// rtl/mem_arb_select.sv - IF/D grant selection; D has priority.
// MEM_ARB_STARVE_EN adds a starvation counter that forces an IF grant after STARVE_LIMIT D grants.
module mem_arb_select
`ifdef MEM_ARB_STARVE_EN
#(
   parameter int STARVE_LIMIT = 4
)
`endif
(
`ifdef MEM_ARB_STARVE_EN
   input  logic clk,
   input  logic rst_n,
`endif
   input  logic idle,
   input  logic if_valid,
   input  logic d_valid,
   output logic grant_if,
   output logic grant_d
);

`ifdef MEM_ARB_STARVE_EN
   localparam int CW = $clog2(STARVE_LIMIT + 1);

   logic [CW-1:0] starve_cnt;
   logic          force_if;

   assign force_if = (starve_cnt >= CW'(STARVE_LIMIT));
   assign grant_d  = idle & d_valid & ~(force_if & if_valid);

   // A grant is always a handshake here, so the counter advances on grants.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (grant_if) begin
         starve_cnt <= '0;
      end else if (grant_d) begin
         starve_cnt <= if_valid ? starve_cnt + CW'(1) : '0;
      end
   end
`else
   assign grant_d  = idle & d_valid;
`endif

   assign grant_if = idle & if_valid & ~grant_d;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port memory between instruction fetch and load/store.
// MEM_ARB_STARVE_EN enables forced IF grants after STARVE_LIMIT consecutive D grants.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW
`ifdef MEM_ARB_STARVE_EN
   ,
   parameter int STARVE_LIMIT = 4
`endif
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req_valid,
   output logic          if_req_ready,
   input  logic [AW-1:0] if_req_addr,
   output logic          if_rsp_valid,
   input  logic          if_rsp_ready,
   output logic [DW-1:0] if_rsp_rdata,
   input  logic          d_req_valid,
   output logic          d_req_ready,
   input  logic          d_req_we,
   input  logic [AW-1:0] d_req_addr,
   input  logic [DW-1:0] d_req_wdata,
   output logic          d_rsp_valid,
   input  logic          d_rsp_ready,
   output logic [DW-1:0] d_rsp_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_datain,
   output logic          mem_sigwr,
   output logic          mem_sigon,
   input  logic [DW-1:0] mem_dataout,
   output logic          busy
);

   state_t        state;
   state_t        state_next;
   logic          lat_id;
   logic          lat_we;
   logic [DW-1:0] lat_wdata;
   logic          grant_if;
   logic          grant_d;
   logic          rsp_accept;

   mem_arb_select
`ifdef MEM_ARB_STARVE_EN
   #(
      .STARVE_LIMIT (STARVE_LIMIT)
   )
`endif
   u_select (
`ifdef MEM_ARB_STARVE_EN
      .clk      (clk),
      .rst_n    (rst_n),
`endif
      .idle     (state == IDLE),
      .if_valid (if_req_valid),
      .d_valid  (d_req_valid),
      .grant_if (grant_if),
      .grant_d  (grant_d)
   );

   assign if_req_ready = grant_if;
   assign d_req_ready  = grant_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      rsp_accept = (lat_id == REQ_D) ? d_rsp_ready : if_rsp_ready;
      unique case (state)
         IDLE:    if (grant_if || grant_d) state_next = ISSUE;
         ISSUE:   state_next = RESP;
         RESP:    if (rsp_accept) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // mem_addr/mem_datain double as the latched request address and data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_id       <= REQ_IF;
         lat_we       <= 1'b0;
         lat_wdata    <= '0;
         mem_addr     <= '0;
         mem_datain   <= '0;
         mem_sigwr    <= 1'b0;
         mem_sigon    <= 1'b0;
         if_rsp_valid <= 1'b0;
         d_rsp_valid  <= 1'b0;
         busy         <= 1'b0;
      end else begin
         mem_sigon <= 1'b0;
         mem_sigwr <= 1'b0;
         busy      <= (state_next != IDLE);
         if (grant_d) begin
            lat_id     <= REQ_D;
            lat_we     <= d_req_we;
            lat_wdata  <= d_req_wdata;
            mem_addr   <= d_req_addr;
            mem_datain <= d_req_wdata;
            mem_sigon  <= 1'b1;
            mem_sigwr  <= d_req_we;
         end else if (grant_if) begin
            lat_id     <= REQ_IF;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
            mem_addr   <= if_req_addr;
            mem_datain <= '0;
            mem_sigon  <= 1'b1;
         end
         if (state == ISSUE) begin
            if_rsp_valid <= (lat_id == REQ_IF);
            d_rsp_valid  <= (lat_id == REQ_D);
         end else if (state == RESP && rsp_accept) begin
            if_rsp_valid <= 1'b0;
            d_rsp_valid  <= 1'b0;
         end
      end
   end

   // The memory only changes dataout when sigon=1, and sigon is 0 for all of RESP,
   // so its output register serves as the load response register.
   assign if_rsp_rdata = if_rsp_valid ? mem_dataout : '0;
   assign d_rsp_rdata  = d_rsp_valid ? (lat_we ? lat_wdata : mem_dataout) : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter with a 32x32 memory model.
// Grant-order expectations follow MEM_ARB_STARVE_EN.
module tb_mem_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready;
   logic [AW-1:0] if_req_addr;
   logic [DW-1:0] if_rsp_rdata;
   logic          d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_ready;
   logic [AW-1:0] d_req_addr;
   logic [DW-1:0] d_req_wdata, d_rsp_rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_datain;
   logic          mem_sigwr, mem_sigon, busy;
   logic [DW-1:0] mem_dataout = '0;

   logic [DW-1:0] mem [0:31];
   logic [31:0]   mem_written = '0;
   int            sigon_cnt = 0;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .if_req_valid (if_req_valid),
      .if_req_ready (if_req_ready),
      .if_req_addr  (if_req_addr),
      .if_rsp_valid (if_rsp_valid),
      .if_rsp_ready (if_rsp_ready),
      .if_rsp_rdata (if_rsp_rdata),
      .d_req_valid  (d_req_valid),
      .d_req_ready  (d_req_ready),
      .d_req_we     (d_req_we),
      .d_req_addr   (d_req_addr),
      .d_req_wdata  (d_req_wdata),
      .d_rsp_valid  (d_rsp_valid),
      .d_rsp_ready  (d_rsp_ready),
      .d_rsp_rdata  (d_rsp_rdata),
      .mem_addr     (mem_addr),
      .mem_datain   (mem_datain),
      .mem_sigwr    (mem_sigwr),
      .mem_sigon    (mem_sigon),
      .mem_dataout  (mem_dataout),
      .busy         (busy)
   );

   // Unwritten words read back as 0x1000_0000 + address.
   always @(posedge clk) begin
      if (mem_sigon === 1'b1) begin
         sigon_cnt <= sigon_cnt + 1;
         if (mem_sigwr) begin
            mem[mem_addr]         <= mem_datain;
            mem_written[mem_addr] <= 1'b1;
            mem_dataout           <= mem_datain;
         end else begin
            mem_dataout <= mem_written[mem_addr] ? mem[mem_addr] : 32'h1000_0000 + 32'(mem_addr);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      int       g;
      int       c;
      logic     got;
      logic [9:0] gvec;
      logic [9:0] gexp;

      rst_n = 1'b0;
      if_req_valid = 0; if_req_addr = '0; if_rsp_ready = 0;
      d_req_valid = 0; d_req_we = 0; d_req_addr = '0; d_req_wdata = '0; d_rsp_ready = 0;

      // Reset held for 3 cycles
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_sigon", 32'(mem_sigon), 0);
      chk("rst_sigwr", 32'(mem_sigwr), 0);
      chk("rst_addr", 32'(mem_addr), 0);
      chk("rst_datain", mem_datain, 0);
      chk("rst_rsp_valids", {30'd0, if_rsp_valid, d_rsp_valid}, 0);
      chk("rst_rdata", if_rsp_rdata | d_rsp_rdata, 0);
      chk("rst_readies", {30'd0, if_req_ready, d_req_ready}, 0);
      chk("rst_sigon_cnt", sigon_cnt, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Store then IF read of the same address
      d_req_valid = 1; d_req_we = 1; d_req_addr = 5; d_req_wdata = 32'hDEADBEEF;
      #1 chk("t2_d_ready", 32'(d_req_ready), 1);
      @(negedge clk);
      d_req_valid = 0;
      chk("t2_issue_sigon", 32'(mem_sigon), 1);
      chk("t2_issue_sigwr", 32'(mem_sigwr), 1);
      chk("t2_issue_addr", 32'(mem_addr), 5);
      chk("t2_issue_datain", mem_datain, 32'hDEADBEEF);
      chk("t2_issue_busy", 32'(busy), 1);
      chk("t2_issue_rsp", 32'(d_rsp_valid), 0);
      @(negedge clk);
      chk("t2_ack_valid", 32'(d_rsp_valid), 1);
      chk("t2_ack_rdata", d_rsp_rdata, 32'hDEADBEEF);
      chk("t2_resp_sigon", 32'(mem_sigon), 0);
      d_rsp_ready = 1;
      @(negedge clk);
      d_rsp_ready = 0;
      chk("t2_idle_valid", 32'(d_rsp_valid), 0);
      chk("t2_idle_busy", 32'(busy), 0);
      if_req_valid = 1; if_req_addr = 5;
      #1 chk("t2_if_ready", 32'(if_req_ready), 1);
      @(negedge clk);
      if_req_valid = 0;
      @(negedge clk);
      chk("t2_if_valid", 32'(if_rsp_valid), 1);
      chk("t2_if_rdata", if_rsp_rdata, 32'hDEADBEEF);
      if_rsp_ready = 1;
      @(negedge clk);
      if_rsp_ready = 0;
      chk("t2_sigon_pulses", sigon_cnt, 2);

      // Simultaneous requests: D first, IF right after D response accepted
      if_req_valid = 1; if_req_addr = 1;
      d_req_valid = 1; d_req_we = 0; d_req_addr = 2;
      #1 chk("t3_readies", {30'd0, if_req_ready, d_req_ready}, 32'b01);
      @(negedge clk);
      d_req_valid = 0;
      chk("t3_issue_addr", 32'(mem_addr), 2);
      chk("t3_issue_if_ready", 32'(if_req_ready), 0);
      @(negedge clk);
      chk("t3_d_rdata", d_rsp_rdata, 32'h1000_0002);
      d_rsp_ready = 1;
      #1 chk("t3_accept_if_ready", 32'(if_req_ready), 0);
      @(negedge clk);
      d_rsp_ready = 0;
      chk("t3_d_done", 32'(d_rsp_valid), 0);
      #1 chk("t3_if_ready_next", 32'(if_req_ready), 1);
      @(negedge clk);
      if_req_valid = 0;
      chk("t3_if_addr", 32'(mem_addr), 1);
      @(negedge clk);
      chk("t3_if_rdata", if_rsp_rdata, 32'h1000_0001);
      if_rsp_ready = 1;
      @(negedge clk);
      if_rsp_ready = 0;

      // D response stalled for 10 cycles with IF waiting
      if_req_valid = 1; if_req_addr = 3;
      d_req_valid = 1; d_req_we = 0; d_req_addr = 5;
      #1 chk("t4_d_ready", 32'(d_req_ready), 1);
      @(negedge clk);
      d_req_valid = 0;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         chk("t4_stall_valid", 32'(d_rsp_valid), 1);
         chk("t4_stall_rdata", d_rsp_rdata, 32'hDEADBEEF);
         chk("t4_stall_if_ready", 32'(if_req_ready), 0);
         chk("t4_stall_sigon", 32'(mem_sigon), 0);
         @(negedge clk);
      end
      d_rsp_ready = 1;
      @(negedge clk);
      d_rsp_ready = 0;
      #1 chk("t4_if_ready", 32'(if_req_ready), 1);
      @(negedge clk);
      if_req_valid = 0;
      @(negedge clk);
      chk("t4_if_rdata", if_rsp_rdata, 32'h1000_0003);
      if_rsp_ready = 1;
      @(negedge clk);
      if_rsp_ready = 0;

      // Both valid continuously: record the first 10 grants (bit=1 means IF)
      if_req_valid = 1; if_req_addr = 0;
      d_req_valid = 1; d_req_we = 0; d_req_addr = 0;
      if_rsp_ready = 1; d_rsp_ready = 1;
      g = 0; c = 0; gvec = '0;
      while (g < 10 && c < 80) begin
         #1;
         if (if_req_ready || d_req_ready) begin
            chk("t5_one_ready", 32'(if_req_ready & d_req_ready), 0);
            gvec[g] = if_req_ready;
            g++;
         end
         @(negedge clk);
         c++;
      end
      if_req_valid = 0; d_req_valid = 0;
`ifdef MEM_ARB_STARVE_EN
      gexp = 10'b10_0001_0000;
`else
      gexp = 10'b00_0000_0000;
`endif
      chk("t5_grant_count", g, 10);
      chk("t5_grant_order", 32'(gvec), 32'(gexp));
      repeat (4) @(negedge clk);
      if_rsp_ready = 0; d_rsp_ready = 0;
      chk("t5_drained", 32'(busy), 0);

      // Reset pulse during ISSUE of a store
      d_req_valid = 1; d_req_we = 1; d_req_addr = 9; d_req_wdata = 32'h1234_5678;
      #1 chk("t6_d_ready", 32'(d_req_ready), 1);
      @(negedge clk);
      d_req_valid = 0; d_req_we = 0;
      chk("t6_issue_sigon", 32'(mem_sigon), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_busy", 32'(busy), 0);
      chk("t6_rst_sigon", 32'(mem_sigon), 0);
      chk("t6_rst_sigwr", 32'(mem_sigwr), 0);
      chk("t6_rst_rsp", {30'd0, if_rsp_valid, d_rsp_valid}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_after_rsp", 32'(d_rsp_valid), 0);
      chk("t6_after_busy", 32'(busy), 0);
      if_req_valid = 1; if_req_addr = 9;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (if_req_ready === 1'b0) if_req_valid = 0;
         if (if_rsp_valid === 1'b1) got = 1'b1;
      end
      chk("t6_if_rsp_seen", 32'(got), 1);
      chk("t6_d_rsp_quiet", 32'(d_rsp_valid), 0);
      if_req_valid = 0;
      if_rsp_ready = 1;
      @(negedge clk);
      if_rsp_ready = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
